// File: rtl/valu_wb_drain_if.sv
// -----------------------------------------------------------------------------
// valu_wb_drain_if
// Bundles the two data paths of the write-back drain:
//   queue side : alu_wr (copy of the queue Write strobe), q_read (pop request),
//                q_data (queue DataOut, valid the cycle after q_read)
//   VRF side   : vrf_we / vrf_ready handshake plus vrf_addr, vrf_elem, vrf_wdata
// master : the drain block (drives q_read and the VRF write port)
// slave  : the environment (queue + VRF)
// -----------------------------------------------------------------------------
interface valu_wb_drain_if #(
  parameter int DW = 32,
  parameter int EW = 5
);
  logic          alu_wr;
  logic          q_read;
  logic [DW-1:0] q_data;
  logic          vrf_we;
  logic          vrf_ready;
  logic [4:0]    vrf_addr;
  logic [EW-1:0] vrf_elem;
  logic [DW-1:0] vrf_wdata;

  modport master (
    input  alu_wr, q_data, vrf_ready,
    output q_read, vrf_we, vrf_addr, vrf_elem, vrf_wdata
  );

  modport slave (
    output alu_wr, q_data, vrf_ready,
    input  q_read, vrf_we, vrf_addr, vrf_elem, vrf_wdata
  );
endinterface

// File: rtl/valu_wb_drain.sv
// -----------------------------------------------------------------------------
// valu_wb_drain
// Reader end of the VALU write-back queue. Mirrors the queue occupancy from the
// ALU-side Write strobe, pops results in FIFO order and writes them one element
// per accepted VRF beat into register vd, elements 0..vl-1.
//
// Ports
//   clk, rst  : clock, synchronous active-high reset
//   start     : begin one instruction (sampled in IDLE only)
//   vd, vl    : destination register and element count, latched on start
//   busy      : high while reading or draining (RUN, DRAIN)
//   done      : one-cycle pulse the cycle after the last element is accepted
//   ovf_err   : sticky, alu_wr seen while the mirrored queue was full
//   bus       : queue pop port and VRF write port (master side)
// -----------------------------------------------------------------------------
module valu_wb_drain #(
  parameter int DW     = 32,
  parameter int QDEPTH = 4,
  parameter int VLMAX  = 32,
  parameter int EW     = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      vd,
  input  logic [EW:0]     vl,
  output logic            busy,
  output logic            done,
  output logic            ovf_err,
  valu_wb_drain_if.master bus
);

  if (EW != $clog2(VLMAX)) begin : g_ew_check
    $error("valu_wb_drain: EW must equal clog2(VLMAX)");
  end

  localparam int            QW    = $clog2(QDEPTH + 1);
  localparam logic [QW-1:0] QONE  = QW'(1);
  localparam logic [QW-1:0] QFULL = QW'(QDEPTH);
  localparam logic [EW:0]   VONE  = (EW + 1)'(1);
  localparam logic [EW-1:0] EONE  = EW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic          ovf_q, ovf_d;
  logic          rd_pend_q, rd_pend_d;
  logic [EW:0]   rd_issued_q, rd_issued_d;
  logic [EW:0]   vl_q, vl_d;
  logic [4:0]    vd_q, vd_d;
  logic [EW-1:0] elem_q, elem_d;
  logic [1:0]    buf_cnt_q, buf_cnt_d;
  logic [DW-1:0] buf0_q, buf0_d;   // head entry, drives the VRF
  logic [DW-1:0] buf1_q, buf1_d;   // skid entry
  logic          q_read;
  logic          pop;
  logic [2:0]    fill;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d     = state_q;
    qcnt_d      = qcnt_q;
    ovf_d       = ovf_q;
    rd_issued_d = rd_issued_q;
    vl_d        = vl_q;
    vd_d        = vd_q;
    elem_d      = elem_q;
    buf_cnt_d   = buf_cnt_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;

    pop  = (buf_cnt_q != 2'd0) && bus.vrf_ready;
    // Entries that will sit in the buffer next cycle if no new read is issued:
    // a read now lands two cycles later, so it must fit behind those.
    fill = {1'b0, buf_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};

    // The queue serves Write first, so never request a pop in an alu_wr cycle.
    q_read = (state_q == RUN) && (rd_issued_q < vl_q) && (qcnt_q != '0) &&
             !bus.alu_wr && (fill < 3'd2);
    rd_pend_d = q_read;

    // Occupancy mirror; alu_wr and q_read are mutually exclusive.
    if (bus.alu_wr) begin
      if (qcnt_q == QFULL) ovf_d = 1'b1;
      else                 qcnt_d = qcnt_q + QONE;
    end else if (q_read) begin
      qcnt_d = qcnt_q - QONE;
    end

    if (q_read) rd_issued_d = rd_issued_q + VONE;
    if (pop)    elem_d      = elem_q + EONE;

    // Two-entry buffer: push captures q_data the cycle after a read.
    unique case ({rd_pend_q, pop})
      2'b10: begin
        if (buf_cnt_q == 2'd0) buf0_d = bus.q_data;
        else                   buf1_d = bus.q_data;
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d    = buf1_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b11: begin
        if (buf_cnt_q == 2'd1) begin
          buf0_d = bus.q_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = bus.q_data;
        end
      end
      default: ;
    endcase

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (vl != '0) begin
            vd_d        = vd;
            vl_d        = vl;
            rd_issued_d = '0;
            elem_d      = '0;
            state_d     = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (rd_issued_q == vl_q) state_d = DRAIN;
      end
      DRAIN: begin
        // Finish once the buffer empties with this cycle's pop, so done
        // follows the final VRF acceptance by exactly one cycle.
        if (!rd_pend_q && (buf_cnt_d == 2'd0)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (rst) begin
      state_q     <= IDLE;
      qcnt_q      <= '0;
      ovf_q       <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_issued_q <= '0;
      vl_q        <= '0;
      vd_q        <= '0;
      elem_q      <= '0;
      buf_cnt_q   <= '0;
      // NOTE: the buffer entries are reset too because buf0 drives vrf_wdata,
      // which must read 0 out of reset.
      buf0_q      <= '0;
      buf1_q      <= '0;
    end else begin
      state_q     <= state_d;
      qcnt_q      <= qcnt_d;
      ovf_q       <= ovf_d;
      rd_pend_q   <= rd_pend_d;
      rd_issued_q <= rd_issued_d;
      vl_q        <= vl_d;
      vd_q        <= vd_d;
      elem_q      <= elem_d;
      buf_cnt_q   <= buf_cnt_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
    end
  end

  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign ovf_err       = ovf_q;
  assign bus.q_read    = q_read;
  assign bus.vrf_we    = (buf_cnt_q != 2'd0);
  assign bus.vrf_addr  = vd_q;
  assign bus.vrf_elem  = elem_q;
  assign bus.vrf_wdata = buf0_q;

endmodule

// File: tb/tb_valu_wb_drain.sv
// -----------------------------------------------------------------------------
// tb_valu_wb_drain
// Directed bench for valu_wb_drain. A small behavioural queue supplies q_data
// one cycle after q_read; expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_valu_wb_drain;
  localparam int DW = 32;
  localparam int EW = 5;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          start  = 1'b0;
  logic [4:0]    vd     = '0;
  logic [EW:0]   vl     = '0;
  logic          busy;
  logic          done;
  logic          ovf_err;
  logic [DW-1:0] wr_val = '0;

  int total = 0;
  int bad   = 0;

  valu_wb_drain_if #(.DW(DW), .EW(EW)) bus ();

  valu_wb_drain #(.DW(DW), .QDEPTH(4), .VLMAX(32), .EW(EW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .vd     (vd),
    .vl     (vl),
    .busy   (busy),
    .done   (done),
    .ovf_err(ovf_err),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Behavioural write-back queue, depth 4, Write has priority over Read.
  logic [DW-1:0] qmodel[$];
  always @(posedge clk) begin
    if (rst) begin
      qmodel.delete();
      bus.q_data <= '0;
    end else if (bus.alu_wr) begin
      if (qmodel.size() < 4) qmodel.push_back(wr_val);
    end else if (bus.q_read && qmodel.size() > 0) begin
      bus.q_data <= qmodel.pop_front();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] v);
    wr_val     = v;
    bus.alu_wr = 1'b1;
    #2;
    check("idle_no_read", 32'(bus.q_read), 0);
    tick;
    bus.alu_wr = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    start = 1'b0;
    bus.alu_wr = 1'b0;
    bus.vrf_ready = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Accepted VRF writes captured by drain_mon.
  logic [DW-1:0] got_data[$];
  logic [EW-1:0] got_elem[$];
  logic [4:0]    got_addr[$];

  // Runs cycles until done, optionally stalling the VRF for stall_len cycles
  // right after the first accepted write; checks vrf_* stay put while stalled.
  task automatic drain_mon(input int stall_len, input int max_cyc,
                           output int rd_in_stall, output int first_rd, output bit saw_done);
    int            stall_left;
    bit            stalled_prev;
    bit            seen_wr;
    logic [DW-1:0] h_data;
    logic [EW-1:0] h_elem;
    logic [4:0]    h_addr;
    stall_left   = 0;
    stalled_prev = 1'b0;
    seen_wr      = 1'b0;
    h_data       = '0;
    h_elem       = '0;
    h_addr       = '0;
    rd_in_stall  = 0;
    first_rd     = -1;
    saw_done     = 1'b0;
    got_data.delete();
    got_elem.delete();
    got_addr.delete();
    for (int c = 0; c < max_cyc; c++) begin
      bus.vrf_ready = (stall_left == 0);
      #2;
      if (bus.q_read && first_rd < 0) first_rd = c;
      if (!bus.vrf_ready) begin
        if (bus.q_read) rd_in_stall++;
        if (stalled_prev) begin
          check("stall_we", 32'(bus.vrf_we), 1);
          check("stall_data", bus.vrf_wdata, h_data);
          check("stall_elem", 32'(bus.vrf_elem), 32'(h_elem));
          check("stall_addr", 32'(bus.vrf_addr), 32'(h_addr));
        end
        h_data       = bus.vrf_wdata;
        h_elem       = bus.vrf_elem;
        h_addr       = bus.vrf_addr;
        stalled_prev = 1'b1;
        stall_left--;
      end else begin
        stalled_prev = 1'b0;
      end
      if (bus.vrf_we && bus.vrf_ready) begin
        got_data.push_back(bus.vrf_wdata);
        got_elem.push_back(bus.vrf_elem);
        got_addr.push_back(bus.vrf_addr);
        if (!seen_wr) begin
          seen_wr    = 1'b1;
          stall_left = stall_len;
        end
      end
      if (done) begin
        saw_done = 1'b1;
        tick;
        break;
      end
      tick;
    end
    bus.vrf_ready = 1'b1;
  endtask

  typedef struct {
    logic          start;
    logic          exp_rd;
    logic          exp_we;
    logic [EW-1:0] exp_elem;
    logic [DW-1:0] exp_data;
    logic          exp_busy;
    logic          exp_done;
  } vec_t;

  vec_t vec[9];

  initial begin
    int rds;
    int first_rd;
    bit saw_done;
    int done_cnt;

    // start, rd, we, elem, data, busy, done -- start accepted in row 0
    vec[0] = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0};
    vec[1] = '{1'b0, 1'b1, 1'b0, 5'd0, 32'h0,         1'b1, 1'b0};
    vec[2] = '{1'b0, 1'b1, 1'b0, 5'd0, 32'h0,         1'b1, 1'b0};
    vec[3] = '{1'b0, 1'b1, 1'b1, 5'd0, 32'hA000_0000, 1'b1, 1'b0};
    vec[4] = '{1'b0, 1'b1, 1'b1, 5'd1, 32'hA000_0001, 1'b1, 1'b0};
    vec[5] = '{1'b0, 1'b0, 1'b1, 5'd2, 32'hA000_0002, 1'b1, 1'b0};
    vec[6] = '{1'b0, 1'b0, 1'b1, 5'd3, 32'hA000_0003, 1'b1, 1'b0};
    vec[7] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 1'b1};
    vec[8] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0};

    bus.alu_wr    = 1'b0;
    bus.vrf_ready = 1'b1;
    do_reset;

    // Reset state.
    #2;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_q_read", 32'(bus.q_read), 0);
    check("rst_vrf_we", 32'(bus.vrf_we), 0);
    check("rst_vrf_elem", 32'(bus.vrf_elem), 0);
    check("rst_vrf_wdata", bus.vrf_wdata, 0);
    check("rst_vrf_addr", 32'(bus.vrf_addr), 0);
    check("rst_ovf", 32'(ovf_err), 0);
    tick;

    // Fill the queue while idle.
    for (int i = 0; i < 4; i++) push(32'hA000_0000 + 32'(i));
    #2;
    check("qcnt_full", 32'(dut.qcnt_q), 4);
    check("idle_full_no_read", 32'(bus.q_read), 0);
    tick;

    // Back-to-back drain of 4 elements, cycle by cycle.
    vd = 5'd7;
    vl = 6'd4;
    for (int i = 0; i < 9; i++) begin
      start = vec[i].start;
      #2;
      check($sformatf("tbl_rd[%0d]", i), 32'(bus.q_read), 32'(vec[i].exp_rd));
      check($sformatf("tbl_we[%0d]", i), 32'(bus.vrf_we), 32'(vec[i].exp_we));
      check($sformatf("tbl_busy[%0d]", i), 32'(busy), 32'(vec[i].exp_busy));
      check($sformatf("tbl_done[%0d]", i), 32'(done), 32'(vec[i].exp_done));
      if (vec[i].exp_we) begin
        check($sformatf("tbl_addr[%0d]", i), 32'(bus.vrf_addr), 7);
        check($sformatf("tbl_elem[%0d]", i), 32'(bus.vrf_elem), 32'(vec[i].exp_elem));
        check($sformatf("tbl_data[%0d]", i), bus.vrf_wdata, vec[i].exp_data);
      end
      tick;
    end
    start = 1'b0;

    // alu_wr during RUN suppresses reads; order preserved.
    push(32'hB000_0000);
    vd = 5'd3;
    vl = 6'd3;
    start = 1'b1;
    #2;
    check("wr_start_no_read", 32'(bus.q_read), 0);
    tick;
    start = 1'b0;
    wr_val = 32'hB000_0001;
    bus.alu_wr = 1'b1;
    #2;
    check("wr_supp_0", 32'(bus.q_read), 0);
    check("wr_busy", 32'(busy), 1);
    tick;
    wr_val = 32'hB000_0002;
    #2;
    check("wr_supp_1", 32'(bus.q_read), 0);
    tick;
    bus.alu_wr = 1'b0;
    drain_mon(0, 30, rds, first_rd, saw_done);
    check("wr_resume_cycle", 32'(first_rd), 0);
    check("wr_done", 32'(saw_done), 1);
    check("wr_count", 32'(got_data.size()), 3);
    for (int i = 0; i < 3 && i < got_data.size(); i++) begin
      check($sformatf("wr_data[%0d]", i), got_data[i], 32'hB000_0000 + 32'(i));
      check($sformatf("wr_elem[%0d]", i), 32'(got_elem[i]), 32'(i));
      check($sformatf("wr_addr[%0d]", i), 32'(got_addr[i]), 3);
    end
    check("wr_qcnt_end", 32'(dut.qcnt_q), 0);

    // VRF backpressure for 5 cycles after the first write.
    for (int i = 0; i < 4; i++) push(32'hC000_0000 + 32'(i));
    vd = 5'd9;
    vl = 6'd4;
    start = 1'b1;
    #2;
    tick;
    start = 1'b0;
    drain_mon(5, 40, rds, first_rd, saw_done);
    check("bp_no_read_while_full", 32'(rds), 0);
    check("bp_done", 32'(saw_done), 1);
    check("bp_count", 32'(got_data.size()), 4);
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      check($sformatf("bp_data[%0d]", i), got_data[i], 32'hC000_0000 + 32'(i));
      check($sformatf("bp_elem[%0d]", i), 32'(got_elem[i]), 32'(i));
      check($sformatf("bp_addr[%0d]", i), 32'(got_addr[i]), 9);
    end

    // Overflow: fifth write with the mirror full.
    for (int i = 0; i < 4; i++) push(32'hE000_0000 + 32'(i));
    #2;
    check("ovf_before", 32'(ovf_err), 0);
    tick;
    push(32'hE000_0004);
    #2;
    check("ovf_set", 32'(ovf_err), 1);
    check("ovf_qcnt_held", 32'(dut.qcnt_q), 4);
    tick;

    // vl=0: done the next cycle, nothing read or written; ovf stays sticky.
    vl = 6'd0;
    start = 1'b1;
    #2;
    check("vl0_c0_read", 32'(bus.q_read), 0);
    tick;
    start = 1'b0;
    #2;
    check("vl0_done", 32'(done), 1);
    check("vl0_busy", 32'(busy), 0);
    check("vl0_read", 32'(bus.q_read), 0);
    check("vl0_we", 32'(bus.vrf_we), 0);
    tick;
    #2;
    check("vl0_done_clear", 32'(done), 0);
    check("ovf_sticky", 32'(ovf_err), 1);
    tick;
    do_reset;
    #2;
    check("ovf_cleared", 32'(ovf_err), 0);
    tick;

    // Reset in the middle of RUN.
    push(32'hD000_0000);
    push(32'hD000_0001);
    vd = 5'd5;
    vl = 6'd4;
    start = 1'b1;
    #2;
    tick;
    start = 1'b0;
    tick;
    tick;
    #2;
    check("mid_busy_before", 32'(busy), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #2;
    check("mid_busy", 32'(busy), 0);
    check("mid_read", 32'(bus.q_read), 0);
    check("mid_we", 32'(bus.vrf_we), 0);
    check("mid_elem", 32'(bus.vrf_elem), 0);
    check("mid_wdata", bus.vrf_wdata, 0);
    check("mid_addr", 32'(bus.vrf_addr), 0);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) done_cnt++;
      tick;
      #2;
    end
    check("mid_no_done", 32'(done_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/valu_wb_drain.md
Name: valu_wb_drain

Overview:
- Reader/drain end of the VALU write-back queue.
- Mirrors the queue occupancy from the ALU-side `Write` strobe, pops results in FIFO order, and writes them element-by-element into the vector register file (VRF) for the active instruction.
- The VRF port honours backpressure.
- Sits between VALU_WBQ (`Read`/`DataOut`) and the VRF write port.

Parameters:
- DW, 32, data width of queue entries and VRF write data.
- QDEPTH, 4, write-back queue depth mirrored by the occupancy counter.
- VLMAX, 32, maximum vector length in elements.
- EW, 5, element index width, equal to clog2(VLMAX).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin draining one instruction; sampled only in IDLE.
- vd  in  5  destination vector register; latched on accepted start.
- vl  in  EW+1  element count, 0..VLMAX; latched on accepted start.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the last element is accepted by the VRF.
- alu_wr  in  1  copy of the queue `Write` strobe.
- q_read  out  1  pop request, driven to the queue `Read`.
- q_data  in  DW  queue `DataOut`; valid the cycle after q_read.
- vrf_we  out  1  VRF write valid.
- vrf_ready  in  1  VRF accepts the write this cycle.
- vrf_addr  out  5  register index; equals the latched vd.
- vrf_elem  out  EW  element index of vrf_wdata.
- vrf_wdata  out  DW  element data.
- ovf_err  out  1  sticky: alu_wr seen while the mirror count equals QDEPTH.

Behaviour:
- Reset: the following outputs and registers reset to 0: busy, done, q_read, vrf_we, vrf_elem, vrf_wdata, vrf_addr, ovf_err, the mirror count, the buffers and all counters. State resets to IDLE. The queue must be reset in the same cycle. Reset mid-instruction discards all in-flight data with no done pulse.
- Mirror count qcnt (0..QDEPTH):
  - +1 on alu_wr.
  - -1 on q_read.
  - alu_wr and q_read are never both high.
  - alu_wr at qcnt==QDEPTH sets ovf_err and holds qcnt.
- Read issue:
  - q_read is combinational.
  - q_read = state==RUN && rd_issued<vl_l && qcnt>0 && !alu_wr && (buf_cnt + rd_pend - pop) < 2.
  - The queue gives `Write` priority, so a read in an alu_wr cycle is never issued.
- rd_pend: register, equal to the previous cycle's q_read.
- Output buffer: 2 entries (output register plus skid).
  - When rd_pend=1, q_data is captured at the end of that cycle.
  - pop = vrf_we && vrf_ready.
  - vrf_we = buf_cnt>0, driven from the head entry.
  - vrf_we, vrf_addr, vrf_elem and vrf_wdata are held stable while vrf_ready=0.
- Element index: vrf_elem starts at 0 per instruction and increments on each pop.
- Latency and throughput: data popped at cycle t is presented on the VRF at cycle t+2. With vrf_ready=1 throughput is 1 element/cycle.
- FSM:
  - IDLE: on start with vl>0, latch vd and vl, clear counters, go to RUN. On start with vl=0, go to DONE.
  - RUN: go to DRAIN when rd_issued==vl_l.
  - DRAIN: go to DONE when rd_pend==0 && buf_cnt==0.
  - DONE: done=1 for one cycle, then IDLE.
  - start outside IDLE is ignored.
- Entries left in the queue after done belong to the next instruction; qcnt persists across instructions.
- alu_wr is tracked in every state, including IDLE.

Test Plan:
- Reset → all outputs 0. Then 4 alu_wr pulses, each with q_data pre-loaded → qcnt=4, q_read stays 0 in IDLE.
- qcnt=4 holding A0..A3, start with vd=7, vl=4, vrf_ready=1 → q_read in cycles 1–4; vrf_we in cycles 3–6 with (vrf_addr, vrf_elem, vrf_wdata) = (7,0,A0) through (7,3,A3); done in cycle 7.
- alu_wr held high for 2 cycles during RUN with qcnt=1 → q_read suppressed in those cycles, then resumes; element order unchanged; qcnt ends 0.
- vl=4, vrf_ready low for 5 cycles after the first write → the vrf_* outputs stay stable, at most 2 elements buffered, no q_read while full; all 4 elements still written in order.
- 5 alu_wr pulses from qcnt=0 with no reads → ovf_err=1 and stays 1 until rst.
- start with vl=0 → done one cycle later, zero q_read and vrf_we. Separately, rst asserted mid-RUN → outputs 0 and IDLE next cycle, no done pulse.
